// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5 key-schedule controller.
// Magic constants are stored zero-extended to 64 bits and narrowed by the user.
package rc5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT_S = 2'd1,
    ST_MIX    = 2'd2,
    ST_READY  = 2'd3
  } state_t;

  localparam logic [15:0] P16 = 16'hB7E1;
  localparam logic [15:0] Q16 = 16'h9E37;
  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;
  localparam logic [63:0] P64 = 64'hB7E151628AED2A6B;
  localparam logic [63:0] Q64 = 64'h9E3779B97F4A7C15;

  // A depth of 1 still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [63:0] magic_p(input int w);
    case (w)
      16:      return {48'd0, P16};
      64:      return P64;
      default: return {32'd0, P32};
    endcase
  endfunction

  function automatic logic [63:0] magic_q(input int w);
    case (w)
      16:      return {48'd0, Q16};
      64:      return Q64;
      default: return {32'd0, Q32};
    endcase
  endfunction

endpackage

// File: rtl/rc5_key_packer.sv
// Packs the key byte stream little-endian into W-bit words and issues L writes.
// A write lands one cycle after the byte that completes (or ends) a word.
module rc5_key_packer
  import rc5_pkg::*;
#(
  parameter int W  = 32,
  parameter int B  = 16,
  parameter int CL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic          restart,
  input  logic [7:0]    key_byte,
  output logic [CL-1:0] l_addr,
  output logic [W-1:0]  l_wdata,
  output logic          l_we,
  output logic          loaded
);

  localparam int LANES = W / 8;

  logic [7:0]   byte_cnt;
  logic [W-1:0] pack;
  logic [7:0]   cnt_eff;
  logic [W-1:0] pack_eff;
  logic [W-1:0] word;
  logic         last;
  logic         flush;
  int           lane;

  // A restart from READY treats the incoming byte as K[0] of a fresh key.
  always_comb begin
    cnt_eff  = restart ? 8'd0 : byte_cnt;
    pack_eff = restart ? '0 : pack;
    lane     = int'(cnt_eff) % LANES;
    word     = pack_eff | ({{(W-8){1'b0}}, key_byte} << (8 * lane));
    last     = (cnt_eff == 8'(B - 1));
    flush    = (lane == LANES - 1) || last;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt <= 8'd0;
      pack     <= '0;
      loaded   <= 1'b0;
      l_we     <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
    end else begin
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      if (accept) begin
        if (flush) begin
          l_we    <= 1'b1;
          l_addr  <= CL'(int'(cnt_eff) / LANES);
          l_wdata <= word;
          pack    <= '0;
        end else begin
          pack <= word;
        end
        byte_cnt <= last ? cnt_eff : cnt_eff + 8'd1;
        loaded   <= last;
      end
    end
  end

endmodule

// File: rtl/rc5_key_sched_ctrl.sv
// RC5 key-schedule sequencer: key load, S table init, mixer hand-off.
// Owns the S/L RAM write and address ports in every state.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | accepting key bytes; waits for iStart with key loaded
//   ST_INIT_S | writes S[i] = P + i*Q for i = 0..T-1
//   ST_MIX    | mixer owns both RAMs until iMix_done
//   ST_READY  | S valid, host reads S; rerun or new key
module rc5_key_sched_ctrl
  import rc5_pkg::*;
#(
  parameter int W = 32,
  parameter int C = 4,
  parameter int T = 26,
  parameter int B = 16,
  parameter logic [W-1:0] P = W'(magic_p(W)),
  parameter logic [W-1:0] Q = W'(magic_q(W)),
  localparam int CL = addr_width(C),
  localparam int TL = addr_width(T)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iKeyValid,
  input  logic [7:0]    iKeyByte,
  output logic          oKeyReady,
  input  logic          iStart,
  input  logic [TL-1:0] iHostSAddr,
  output logic          oBusy,
  output logic          oDone,
  output logic [TL-1:0] oS_addr,
  output logic [W-1:0]  oS_wdata,
  output logic          oS_we,
  output logic [CL-1:0] oL_addr,
  output logic [W-1:0]  oL_wdata,
  output logic          oL_we,
  output logic          oMixStart,
  input  logic [TL-1:0] iMix_S_addr,
  input  logic [W-1:0]  iMix_S_wdata,
  input  logic          iMix_S_we,
  input  logic [CL-1:0] iMix_L_addr,
  input  logic [W-1:0]  iMix_L_wdata,
  input  logic          iMix_L_we,
  input  logic          iMix_done
);

  state_t        state, state_nxt;
  logic [TL-1:0] idx;
  logic [W-1:0]  s_acc;
  logic          key_loaded;
  logic          accept;
  logic          restart;
  logic          load_init;
  logic [CL-1:0] pk_addr;
  logic [W-1:0]  pk_wdata;
  logic          pk_we;

  assign oKeyReady = (state == ST_READY) || !key_loaded;
  assign accept    = iKeyValid && oKeyReady;
  assign restart   = (state == ST_READY) && iKeyValid;
  assign load_init = (state_nxt == ST_INIT_S) && (state != ST_INIT_S);

  rc5_key_packer #(
    .W  (W),
    .B  (B),
    .CL (CL)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept),
    .restart  (restart),
    .key_byte (iKeyByte),
    .l_addr   (pk_addr),
    .l_wdata  (pk_wdata),
    .l_we     (pk_we),
    .loaded   (key_loaded)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      s_acc <= '0;
    end else begin
      state <= state_nxt;
      if (load_init) begin
        idx   <= '0;
        s_acc <= P;
      end else if (state == ST_INIT_S) begin
        idx   <= idx + TL'(1);
        s_acc <= s_acc + Q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    oMixStart = 1'b0;
    oS_addr   = '0;
    oS_wdata  = '0;
    oS_we     = 1'b0;
    oL_addr   = pk_addr;
    oL_wdata  = pk_wdata;
    oL_we     = pk_we;
    case (state)
      ST_IDLE: begin
        if (iStart && key_loaded) state_nxt = ST_INIT_S;
      end
      ST_INIT_S: begin
        oBusy    = 1'b1;
        oS_we    = 1'b1;
        oS_addr  = idx;
        oS_wdata = s_acc;
        if (idx == TL'(T - 1)) state_nxt = ST_MIX;
      end
      ST_MIX: begin
        // The mixer's last write shares the cycle with iMix_done, so routing stays on.
        oBusy     = 1'b1;
        oMixStart = 1'b1;
        oS_addr   = iMix_S_addr;
        oS_wdata  = iMix_S_wdata;
        oS_we     = iMix_S_we;
        oL_addr   = iMix_L_addr;
        oL_wdata  = iMix_L_wdata;
        oL_we     = iMix_L_we;
        if (iMix_done) state_nxt = ST_READY;
      end
      ST_READY: begin
        oDone   = 1'b1;
        oS_addr = iHostSAddr;
        if (iKeyValid)   state_nxt = ST_IDLE;
        else if (iStart) state_nxt = ST_INIT_S;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// Self-checking bench: random keys, RAM models and a mixer stub, checked
// against an arithmetic model of key packing and the S init progression.
module tb_rc5_key_sched_ctrl;

  localparam logic [31:0] P = 32'hB7E15163;
  localparam logic [31:0] Q = 32'h9E3779B9;
  localparam logic [31:0] FINAL_WORD = 32'hFACE0005;

  logic        clk;
  logic        rst;
  logic        iKeyValid;
  logic [7:0]  iKeyByte;
  logic        oKeyReady;
  logic        iStart;
  logic [4:0]  iHostSAddr;
  logic        oBusy, oDone;
  logic [4:0]  oS_addr;
  logic [31:0] oS_wdata;
  logic        oS_we;
  logic [1:0]  oL_addr;
  logic [31:0] oL_wdata;
  logic        oL_we;
  logic        oMixStart;
  logic [4:0]  iMix_S_addr;
  logic [31:0] iMix_S_wdata;
  logic        iMix_S_we;
  logic [1:0]  iMix_L_addr;
  logic [31:0] iMix_L_wdata;
  logic        iMix_L_we;
  logic        iMix_done;

  // second instance: B=10, C=3
  logic        k2_valid;
  logic [7:0]  k2_byte;
  logic        k2_ready;
  logic        d2_busy, d2_done, d2_s_we, d2_l_we, d2_mix;
  logic [4:0]  d2_s_addr;
  logic [31:0] d2_s_wdata, d2_l_wdata;
  logic [1:0]  d2_l_addr;
  logic        zero1;
  logic [4:0]  zero5;
  logic [1:0]  zero2;
  logic [31:0] zero32;

  int total = 0;
  int bad = 0;

  logic [31:0] s_ram [26];
  logic [31:0] l_ram [4];
  logic [31:0] l2_ram [3];
  int s_wr = 0, l_wr = 0, l2_wr = 0;
  int mix_cnt = 0;
  logic [7:0] key [16];

  rc5_key_sched_ctrl dut (
    .clk(clk), .rst(rst), .iKeyValid(iKeyValid), .iKeyByte(iKeyByte),
    .oKeyReady(oKeyReady), .iStart(iStart), .iHostSAddr(iHostSAddr),
    .oBusy(oBusy), .oDone(oDone), .oS_addr(oS_addr), .oS_wdata(oS_wdata),
    .oS_we(oS_we), .oL_addr(oL_addr), .oL_wdata(oL_wdata), .oL_we(oL_we),
    .oMixStart(oMixStart), .iMix_S_addr(iMix_S_addr), .iMix_S_wdata(iMix_S_wdata),
    .iMix_S_we(iMix_S_we), .iMix_L_addr(iMix_L_addr), .iMix_L_wdata(iMix_L_wdata),
    .iMix_L_we(iMix_L_we), .iMix_done(iMix_done)
  );

  rc5_key_sched_ctrl #(.W(32), .C(3), .T(26), .B(10)) dut2 (
    .clk(clk), .rst(rst), .iKeyValid(k2_valid), .iKeyByte(k2_byte),
    .oKeyReady(k2_ready), .iStart(zero1), .iHostSAddr(zero5),
    .oBusy(d2_busy), .oDone(d2_done), .oS_addr(d2_s_addr), .oS_wdata(d2_s_wdata),
    .oS_we(d2_s_we), .oL_addr(d2_l_addr), .oL_wdata(d2_l_wdata), .oL_we(d2_l_we),
    .oMixStart(d2_mix), .iMix_S_addr(zero5), .iMix_S_wdata(zero32),
    .iMix_S_we(zero1), .iMix_L_addr(zero2), .iMix_L_wdata(zero32),
    .iMix_L_we(zero1), .iMix_done(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (oS_we && int'(oS_addr) < 26) begin s_ram[oS_addr] <= oS_wdata; s_wr++; end
    if (oL_we) begin l_ram[oL_addr] <= oL_wdata; l_wr++; end
    if (d2_l_we && int'(d2_l_addr) < 3) begin l2_ram[d2_l_addr] <= d2_l_wdata; l2_wr++; end
    mix_cnt <= oMixStart ? mix_cnt + 1 : 0;
  end

  function automatic logic [31:0] stub_word(input int c);
    return 32'hC0DE0000 + 32'(c);
  endfunction

  // Mixer stub: one S and one L write per cycle, done on the 20th cycle
  // together with a final write to S[5].
  always_comb begin
    iMix_S_we = 1'b0; iMix_S_addr = '0; iMix_S_wdata = '0;
    iMix_L_we = 1'b0; iMix_L_addr = '0; iMix_L_wdata = '0;
    iMix_done = 1'b0;
    if (oMixStart) begin
      iMix_S_we    = 1'b1;
      iMix_S_addr  = (mix_cnt == 19) ? 5'd5 : 5'(mix_cnt);
      iMix_S_wdata = (mix_cnt == 19) ? FINAL_WORD : stub_word(mix_cnt);
      iMix_L_we    = 1'b1;
      iMix_L_addr  = 2'(mix_cnt % 4);
      iMix_L_wdata = 32'h1000 + 32'(mix_cnt);
      iMix_done    = (mix_cnt == 19);
    end
  end

  function automatic logic [31:0] s_init(input int k);
    longint v;
    v = longint'(P) + longint'(k) * longint'(Q);
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_l(input int j);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      if (i / 4 == j) w |= {24'd0, key[i]} << (8 * (i % 4));
    return w;
  endfunction

  function automatic logic [31:0] exp_s_after_mix(input int i);
    if (i == 5) return FINAL_WORD;
    if (i <= 18) return stub_word(i);
    return s_init(i);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Feeds key[from..15]; bytes are offered with random gaps when asked.
  task automatic load_key(input int from, input bit gaps, output int cycles);
    int i;
    bit acc;
    i = from;
    cycles = 0;
    while (i < 16 && cycles < 200) begin
      iKeyValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      iKeyByte  = key[i];
      acc = iKeyValid && oKeyReady;
      tick();
      cycles++;
      if (acc) i++;
    end
    iKeyValid = 1'b0;
    total++;
    if (i != 16) begin
      bad++;
      $display("FAIL load_key_complete accepted=%0d required=16", i);
    end
  endtask

  task automatic test_reset();
    logic [76:0] obs;
    rst = 1'b0; iKeyValid = 0; iKeyByte = 0; iStart = 0; iHostSAddr = 0;
    k2_valid = 0; k2_byte = 0;
    tick(); tick();
    obs = {oKeyReady, oBusy, oDone, oMixStart, oS_we, oL_we, oS_addr, oS_wdata, oL_addr, oL_wdata};
    total++;
    if (obs !== {1'b1, 76'd0}) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs, {1'b1, 76'd0});
    end
    rst = 1'b1;
    tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    total++;
    if (oBusy !== 1'b0 || oS_we !== 1'b0) begin
      bad++;
      $display("FAIL start_without_key busy=%b s_we=%b want 0 0", oBusy, oS_we);
    end
  endtask

  task automatic test_key_seq();
    int cyc;
    for (int i = 0; i < 16; i++) key[i] = 8'(i);
    l_wr = 0;
    load_key(0, 1'b0, cyc);
    total++;
    if (cyc != 16) begin bad++; $display("FAIL back_to_back_cycles got=%0d want=16", cyc); end
    total++;
    if (oKeyReady !== 1'b0) begin bad++; $display("FAIL ready_after_key got=%b want=0", oKeyReady); end
    tick();
    total++;
    if (l_wr != 4) begin bad++; $display("FAIL l_write_count got=%0d want=4", l_wr); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (l_ram[j] !== exp_l(j)) begin
        bad++;
        $display("FAIL l_word[%0d] got=%h want=%h", j, l_ram[j], exp_l(j));
      end
    end
    total++;
    if (l_ram[3] !== 32'h0F0E0D0C) begin bad++; $display("FAIL l_word3_const got=%h want=0f0e0d0c", l_ram[3]); end
  endtask

  task automatic test_short_key();
    l2_wr = 0;
    for (int i = 0; i < 10; i++) begin
      k2_valid = 1'b1;
      k2_byte  = 8'(i);
      total++;
      if (k2_ready !== 1'b1) begin bad++; $display("FAIL short_ready[%0d] got=%b want=1", i, k2_ready); end
      tick();
    end
    k2_valid = 1'b0;
    tick(); tick();
    total++;
    if (l2_wr != 3) begin bad++; $display("FAIL short_l_writes got=%0d want=3", l2_wr); end
    total++;
    if (l2_ram[2] !== 32'h00000908 || l2_ram[0] !== 32'h03020100 || l2_ram[1] !== 32'h07060504) begin
      bad++;
      $display("FAIL short_l_words got=%h %h %h want=03020100 07060504 00000908", l2_ram[0], l2_ram[1], l2_ram[2]);
    end
    total++;
    if (k2_ready !== 1'b0) begin bad++; $display("FAIL short_ready_after got=%b want=0", k2_ready); end
  endtask

  task automatic test_init();
    s_wr = 0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int k = 0; k < 26; k++) begin
      total++;
      if (oS_we !== 1'b1 || int'(oS_addr) != k || oS_wdata !== s_init(k) || oBusy !== 1'b1) begin
        bad++;
        $display("FAIL init_write[%0d] got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                 k, oS_we, oS_addr, oS_wdata, k, s_init(k));
      end
      tick();
    end
    total++;
    if (oMixStart !== 1'b1 || s_wr != 26) begin
      bad++;
      $display("FAIL init_to_mix got mix=%b writes=%0d want mix=1 writes=26", oMixStart, s_wr);
    end
    total++;
    if (s_ram[0] !== 32'hB7E15163 || s_ram[1] !== 32'h5618CB1C || s_ram[2] !== 32'hF45044D5 || s_ram[25] !== s_init(25)) begin
      bad++;
      $display("FAIL init_values got=%h %h %h %h want=b7e15163 5618cb1c f45044d5 %h",
               s_ram[0], s_ram[1], s_ram[2], s_ram[25], s_init(25));
    end
  endtask

  task automatic test_mix();
    int n;
    n = 0;
    while (oDone !== 1'b1 && n < 40) begin tick(); n++; end
    total++;
    if (n != 20) begin bad++; $display("FAIL done_latency got=%0d want=20", n); end
    total++;
    if (oMixStart !== 1'b0 || oBusy !== 1'b0 || oS_we !== 1'b0 || oL_we !== 1'b0) begin
      bad++;
      $display("FAIL ready_outputs got mix=%b busy=%b s_we=%b l_we=%b want 0 0 0 0", oMixStart, oBusy, oS_we, oL_we);
    end
    iHostSAddr = 5'd5;
    #1;
    total++;
    if (oS_addr !== 5'd5 || s_ram[oS_addr] !== FINAL_WORD) begin
      bad++;
      $display("FAIL host_read5 got addr=%0d data=%h want addr=5 data=%h", oS_addr, s_ram[oS_addr], FINAL_WORD);
    end
    for (int i = 0; i < 26; i++) begin
      total++;
      if (s_ram[i] !== exp_s_after_mix(i)) begin
        bad++;
        $display("FAIL s_after_mix[%0d] got=%h want=%h", i, s_ram[i], exp_s_after_mix(i));
      end
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (l_ram[j] !== 32'h1010 + 32'(j)) begin
        bad++;
        $display("FAIL l_after_mix[%0d] got=%h want=%h", j, l_ram[j], 32'h1010 + 32'(j));
      end
    end
    tick(); tick(); tick();
    total++;
    if (oDone !== 1'b1) begin bad++; $display("FAIL done_held got=%b want=1", oDone); end
    iHostSAddr = 5'd0;
  endtask

  task automatic test_reset_mid_init();
    logic [76:0] obs;
    int n, cyc;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    n = 0;
    while (!(oS_we === 1'b1 && oS_addr === 5'd10) && n < 40) begin tick(); n++; end
    total++;
    if (n >= 40) begin bad++; $display("FAIL rerun_reach_idx10 got=timeout want=idx 10"); end
    rst = 1'b0;
    tick();
    obs = {oKeyReady, oBusy, oDone, oMixStart, oS_we, oL_we, oS_addr, oS_wdata, oL_addr, oL_wdata};
    total++;
    if (obs !== {1'b1, 76'd0}) begin
      bad++;
      $display("FAIL mid_init_reset got=%h want=%h", obs, {1'b1, 76'd0});
    end
    rst = 1'b1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    total++;
    if (oBusy !== 1'b0 || oS_we !== 1'b0) begin
      bad++;
      $display("FAIL start_after_reset busy=%b s_we=%b want 0 0", oBusy, oS_we);
    end
    for (int i = 0; i < 16; i++) key[i] = 8'($urandom);
    l_wr = 0;
    load_key(0, 1'b1, cyc);
    tick();
    total++;
    if (l_wr != 4) begin bad++; $display("FAIL rand_l_writes got=%0d want=4", l_wr); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (l_ram[j] !== exp_l(j)) begin
        bad++;
        $display("FAIL rand_l_word[%0d] got=%h want=%h", j, l_ram[j], exp_l(j));
      end
    end
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    total++;
    if (oBusy !== 1'b1 || oS_addr !== 5'd0 || oS_wdata !== P) begin
      bad++;
      $display("FAIL restart_first_write got busy=%b addr=%0d data=%h want 1 0 %h", oBusy, oS_addr, oS_wdata, P);
    end
    n = 0;
    while (oDone !== 1'b1 && n < 80) begin tick(); n++; end
    total++;
    if (n >= 80) begin bad++; $display("FAIL rerun_done got=timeout want=done"); end
  endtask

  task automatic test_start_and_key();
    int cyc;
    for (int i = 0; i < 16; i++) key[i] = 8'($urandom);
    l_wr = 0;
    iKeyValid = 1'b1;
    iKeyByte  = key[0];
    iStart    = 1'b1;
    total++;
    if (oKeyReady !== 1'b1) begin bad++; $display("FAIL ready_in_ready_state got=%b want=1", oKeyReady); end
    tick();
    iKeyValid = 1'b0;
    iStart    = 1'b0;
    total++;
    if (oBusy !== 1'b0 || oS_we !== 1'b0 || oDone !== 1'b0 || oKeyReady !== 1'b1) begin
      bad++;
      $display("FAIL key_beats_start got busy=%b s_we=%b done=%b ready=%b want 0 0 0 1",
               oBusy, oS_we, oDone, oKeyReady);
    end
    load_key(1, 1'b1, cyc);
    tick();
    total++;
    if (l_wr != 4) begin bad++; $display("FAIL newkey_l_writes got=%0d want=4", l_wr); end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (l_ram[j] !== exp_l(j)) begin
        bad++;
        $display("FAIL newkey_l_word[%0d] got=%h want=%h", j, l_ram[j], exp_l(j));
      end
    end
  endtask

  initial begin
    zero1 = 1'b0; zero2 = '0; zero5 = '0; zero32 = '0;
    test_reset();
    test_key_seq();
    test_short_key();
    test_init();
    test_mix();
    test_reset_mid_init();
    test_start_and_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rc5_key_sched_ctrl.md
# rc5_key_sched_ctrl

Sequencer for the RC5 key schedule. It packs host key bytes into the L table, initialises the S table with the P/Q magic-constant progression, then hands both RAM ports to the key mixer and waits for it to finish. It sits between the host interface, the two single-port table RAMs (S: T words, L: C words) and the key mixer, and owns arbitration of the RAM write/address ports.

## Interface
Parameters:
- W, 32, word width (16/32/64)
- C, 4, L table depth in words; must equal ceil(B*8/W)
- T, 26, S table depth, 2*(rounds+1)
- B, 16, key length in bytes, 1..255
- P, 32'hB7E15163, first S value (W bits)
- Q, 32'h9E3779B9, S increment (W bits)

Ports (derived widths: CL = $clog2(C), TL = $clog2(T)):
- clk  in  1  clock; everything is on its rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- iKeyValid  in  1  key byte valid
- iKeyByte  in  8  key byte, sent in order K[0]..K[B-1]
- oKeyReady  out  1  byte accepted when iKeyValid & oKeyReady
- iStart  in  1  start-schedule request, sampled each cycle
- iHostSAddr  in  TL  S read address for the host, used in READY only
- oBusy  out  1  INIT_S or MIX active
- oDone  out  1  schedule complete, S valid
- oS_addr  out  TL  S RAM address
- oS_wdata  out  W  S RAM write data
- oS_we  out  1  S RAM write enable
- oL_addr  out  CL  L RAM address
- oL_wdata  out  W  L RAM write data
- oL_we  out  1  L RAM write enable
- oMixStart  out  1  mixer enable, level; low holds the mixer in reset
- iMix_S_addr  in  TL  mixer S address
- iMix_S_wdata  in  W  mixer S write data
- iMix_S_we  in  1  mixer S write enable
- iMix_L_addr  in  CL  mixer L address
- iMix_L_wdata  in  W  mixer L write data
- iMix_L_we  in  1  mixer L write enable
- iMix_done  in  1  mixer finished, level

RAM read data is wired directly to the mixer outside this block.

## Operation
States: IDLE, INIT_S, MIX, READY. Flag rKeyLoaded; byte counter rByteCnt (8 bits); index rIdx (TL bits); accumulator rS (W bits); pack register rPack (W bits).

- **IDLE, key loading.** oKeyReady = !rKeyLoaded.
  - Each accepted byte goes into rPack lane rByteCnt % (W/8), little-endian.
  - A word is written when its lane is the last lane or the byte is the last key byte (rByteCnt == B-1). The write drives oL_we=1, oL_addr = rByteCnt/(W/8) and oL_wdata = the packed word. Unfilled upper lanes are 0.
  - rPack clears after each write.
  - The last byte sets rKeyLoaded.
- **IDLE → INIT_S** when iStart & rKeyLoaded. iStart without rKeyLoaded is ignored.
- **INIT_S.** Lasts T cycles.
  - Drives oS_we=1, oS_addr=rIdx, oS_wdata=rS.
  - rIdx starts at 0 and increments each cycle; rS starts at P and takes rS+Q each cycle (mod 2^W).
  - At rIdx == T-1, go to MIX.
- **MIX.**
  - oMixStart=1.
  - S and L address, wdata and we are muxed from the iMix_* ports.
  - When iMix_done=1, go to READY. The mixer's final write is asserted in that same cycle and must still be routed.
- **READY.**
  - oDone=1, oMixStart=0.
  - oS_addr = iHostSAddr, all we=0.
  - iStart reruns the schedule (→ INIT_S) with the key kept.
  - iKeyValid starts a new key: rKeyLoaded=0, rByteCnt=0, and the first byte is accepted in the same cycle (oKeyReady=1 in READY). Next state is IDLE.
  - If iStart and iKeyValid are both high, iKeyValid wins.
- **Outside MIX**, oMixStart=0 and the iMix_* ports are ignored.
- **Outputs** are decoded from state and registers. With no active write, we=0 and the address/data outputs are 0.

## Timing
- Reset (rst=0 at an edge), from any state including mid-INIT_S or mid-MIX:
  - state=IDLE; all counters, rPack, rS and rKeyLoaded are 0.
  - oBusy=0, oDone=0, oMixStart=0; all we=0, all addr/wdata=0.
  - oKeyReady=1.
  - Partially written tables are not restored.
- iStart sampled high at edge n → first S write (addr 0, data P) in cycle n+1; last init write in cycle n+T; oMixStart high from cycle n+T+1.
- A key byte accepted at edge n → L write, if due, in cycle n+1. Back-to-back bytes are accepted every cycle.
- oDone rises the cycle after iMix_done is sampled high, and stays high until a new key byte or iStart.
- oBusy = (state==INIT_S) | (state==MIX).

## Structure
- Shared package rc5_pkg holds:
  - state encodings;
  - P/Q constants for W=16 (B7E1/9E37), W=32 (B7E15163/9E3779B9) and W=64 (B7E151628AED2A6B/9E3779B97F4A7C15);
  - CL/TL width functions.
- Sub-module rc5_key_packer: byte-to-word packing, byte counter, L write generation. Interface: byte stream in; oL_addr/oL_wdata/oL_we and a done flag out.

## Test plan
Every scenario uses a behavioural mixer stub that writes known words and raises iMix_done after 20 cycles.
- Bytes 00..0F with B=16, W=32 → L[0]=03020100, L[1]=07060504, L[2]=0B0A0908, L[3]=0F0E0D0C; oKeyReady=0 after the 16th byte.
- B=10, C=3, bytes 00..09 → L[2]=00000908; exactly 3 L writes.
- iStart after key load → S[0]=B7E15163, S[1]=5618CB1C, S[2]=F45044D5, S[25]=P+25*Q mod 2^32; exactly 26 init writes, then oMixStart=1.
- Stub's final write coincides with iMix_done → that write reaches the RAM; oDone=1 on the next cycle; oMixStart=0; reading address 5 via iHostSAddr returns the stub's value.
- rst=0 during INIT_S at rIdx=10 → the next cycle has all outputs at their reset values and oKeyReady=1; iStart is then ignored until a new key is fully loaded.
- iStart before any key load → ignored. iStart and iKeyValid together in READY → byte accepted, no new init.
